// File: rtl/bus_arbiter_pkg.sv
// Shared types for bus_arbiter: requester IDs, FSM states and the arbitration pick helper.
package bus_arbiter_pkg;

  typedef enum logic {
    ARB_INSTR = 1'b0,
    ARB_DATA  = 1'b1
  } arb_id_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // With rr_mode set, the requester granted last loses a collision; otherwise data always wins.
  function automatic arb_id_e arb_pick(input logic i_act, input logic d_act,
                                       input logic rr_mode, input arb_id_e last_gnt);
    arb_id_e pick;
    if (i_act && d_act) begin
      if (rr_mode && (last_gnt == ARB_DATA)) pick = ARB_INSTR;
      else                                   pick = ARB_DATA;
    end else if (i_act) begin
      pick = ARB_INSTR;
    end else begin
      pick = ARB_DATA;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_arbiter_id_fifo.sv
// arb_id_fifo: 1-bit wide synchronous FIFO tracking which requester owns each outstanding read.
// A push while full is accepted only when a pop happens in the same cycle.
module arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full    = (cnt_q == (PW+1)'(DEPTH));
    empty   = (cnt_q == '0);
    dout    = mem_q[rptr_q];
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester (instr/data) arbiter onto one shared memory port with in-order read return.
// Define BUS_ARB_RR_EN for round-robin arbitration; default is fixed data-over-instr priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OUTST_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iram_req,
  input  logic              iram_write,
  input  logic [XLEN/8-1:0] iram_wstrb,
  input  logic [XLEN-1:0]   iram_addr,
  input  logic [XLEN-1:0]   iram_wdata,
  output logic              iram_ready,
  output logic              iram_rvalid,
  output logic [XLEN-1:0]   iram_rdata,
  input  logic              dram_req,
  input  logic              dram_write,
  input  logic [XLEN/8-1:0] dram_wstrb,
  input  logic [XLEN-1:0]   dram_addr,
  input  logic [XLEN-1:0]   dram_wdata,
  output logic              dram_ready,
  output logic              dram_rvalid,
  output logic [XLEN-1:0]   dram_rdata,
  output logic              ram_req,
  output logic              ram_write,
  output logic [XLEN/8-1:0] ram_wstrb,
  output logic [XLEN-1:0]   ram_addr,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic              ram_ready,
  input  logic              ram_rvalid,
  input  logic [XLEN-1:0]   ram_rdata
);

  arb_state_e state_q, state_d;
  arb_id_e    gnt_q, gnt_d;
  arb_id_e    gnt, pick;
  logic       fifo_full, fifo_empty, fifo_head;
  logic       blk_rd, i_act, d_act, sel_act;
  logic       xfer, push, pop;

`ifdef BUS_ARB_RR_EN
  arb_id_e last_q, last_d;

  always_comb last_d = xfer ? gnt : last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= ARB_INSTR;
    else     last_q <= last_d;
  end

  always_comb pick = arb_pick(i_act, d_act, 1'b1, last_q);
`else
  always_comb pick = arb_pick(i_act, d_act, 1'b0, ARB_INSTR);
`endif

  // A pop in the same cycle frees a slot, so a full FIFO only blocks reads without a concurrent return.
  always_comb begin
    blk_rd  = fifo_full && !ram_rvalid;
    i_act   = iram_req && !(blk_rd && !iram_write);
    d_act   = dram_req && !(blk_rd && !dram_write);
    gnt     = (state_q == HOLD) ? gnt_q : pick;
    sel_act = (gnt == ARB_DATA) ? d_act : i_act;

    ram_req   = sel_act;
    ram_write = (gnt == ARB_DATA) ? dram_write : iram_write;
    ram_wstrb = (gnt == ARB_DATA) ? dram_wstrb : iram_wstrb;
    ram_addr  = (gnt == ARB_DATA) ? dram_addr  : iram_addr;
    ram_wdata = (gnt == ARB_DATA) ? dram_wdata : iram_wdata;

    iram_ready = ram_ready && sel_act && (gnt == ARB_INSTR);
    dram_ready = ram_ready && sel_act && (gnt == ARB_DATA);

    xfer = ram_req && ram_ready;
    push = xfer && !ram_write;
    pop  = ram_rvalid && !fifo_empty;

    iram_rvalid = pop && (arb_id_e'(fifo_head) == ARB_INSTR);
    dram_rvalid = pop && (arb_id_e'(fifo_head) == ARB_DATA);
    iram_rdata  = ram_rdata;
    dram_rdata  = ram_rdata;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (ram_req && !ram_ready) begin
          state_d = HOLD;
          gnt_d   = gnt;
        end
      end
      HOLD: begin
        if (!ram_req || ram_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= ARB_INSTR;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
    end
  end

  arb_id_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (gnt == ARB_DATA),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stray returns with nothing outstanding (e.g. after reset) must never reach a requester.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    (ram_rvalid && fifo_empty) |-> !(iram_rvalid || dram_rvalid));

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected transfers and read returns are queued by the
// stimulus and consumed by a negedge monitor; cycle-specific conditions are checked inline.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              iram_req, iram_write, iram_ready, iram_rvalid;
  logic [XLEN/8-1:0] iram_wstrb;
  logic [XLEN-1:0]   iram_addr, iram_wdata, iram_rdata;
  logic              dram_req, dram_write, dram_ready, dram_rvalid;
  logic [XLEN/8-1:0] dram_wstrb;
  logic [XLEN-1:0]   dram_addr, dram_wdata, dram_rdata;
  logic              ram_req, ram_write, ram_ready, ram_rvalid;
  logic [XLEN/8-1:0] ram_wstrb;
  logic [XLEN-1:0]   ram_addr, ram_wdata, ram_rdata;

  typedef struct packed {
    logic        id;
    logic        wr;
    logic [31:0] val;
  } ev_t;

  ev_t xfer_q[$];
  ev_t resp_q[$];
  int  checks   = 0;
  int  failures = 0;

  bus_arbiter #(.XLEN(XLEN), .OUTST_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .iram_req(iram_req), .iram_write(iram_write), .iram_wstrb(iram_wstrb),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata),
    .iram_ready(iram_ready), .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
    .dram_req(dram_req), .dram_write(dram_write), .dram_wstrb(dram_wstrb),
    .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_ready(dram_ready), .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
    .ram_req(ram_req), .ram_write(ram_write), .ram_wstrb(ram_wstrb),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ready(ram_ready), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv_i(input logic req, input logic wr, input logic [31:0] addr);
    iram_req = req; iram_write = wr; iram_addr = addr;
    iram_wdata = addr ^ 32'hA5A5_A5A5; iram_wstrb = 4'hF;
  endtask

  task automatic drv_d(input logic req, input logic wr, input logic [31:0] addr);
    dram_req = req; dram_write = wr; dram_addr = addr;
    dram_wdata = addr ^ 32'h5A5A_5A5A; dram_wstrb = 4'h3;
  endtask

  task automatic drv_ram(input logic rdy, input logic rv, input logic [31:0] data);
    ram_ready = rdy; ram_rvalid = rv; ram_rdata = data;
  endtask

  task automatic idle_all();
    drv_i(1'b0, 1'b0, 32'h0);
    drv_d(1'b0, 1'b0, 32'h0);
    drv_ram(1'b0, 1'b0, 32'h0);
  endtask

  task automatic exp_x(input logic id, input logic wr, input logic [31:0] addr);
    xfer_q.push_back('{id: id, wr: wr, val: addr});
  endtask

  task automatic exp_r(input logic id, input logic [31:0] data);
    resp_q.push_back('{id: id, wr: 1'b0, val: data});
  endtask

  // Monitor: every accepted transfer and every routed read return is matched against the queues.
  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      if (ram_req && ram_ready) begin
        checks++;
        if (xfer_q.size() == 0) begin
          failures++;
          $display("FAIL xfer_unexpected: got addr %h with no transfer expected", ram_addr);
        end else begin
          e = xfer_q.pop_front();
          if ((iram_ready == dram_ready) || (dram_ready !== e.id) ||
              (ram_addr !== e.val) || (ram_write !== e.wr)) begin
            failures++;
            $display("FAIL xfer: got id=%0d rdy_i=%0b rdy_d=%0b wr=%0b addr=%h expected id=%0d wr=%0b addr=%h",
                     dram_ready, iram_ready, dram_ready, ram_write, ram_addr, e.id, e.wr, e.val);
          end
        end
      end
      if (iram_rvalid || dram_rvalid) begin
        checks++;
        if (resp_q.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected: got rvalid_i=%0b rvalid_d=%0b with no read outstanding",
                   iram_rvalid, dram_rvalid);
        end else begin
          e = resp_q.pop_front();
          if ((iram_rvalid == dram_rvalid) || (dram_rvalid !== e.id) ||
              ((e.id ? dram_rdata : iram_rdata) !== e.val)) begin
            failures++;
            $display("FAIL resp: got rvalid_i=%0b rvalid_d=%0b rdata=%h expected id=%0d rdata=%h",
                     iram_rvalid, dram_rvalid, ram_rdata, e.id, e.val);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {ram_req, iram_ready, dram_ready, iram_rvalid, dram_rvalid}, 32'h0);
    tick(); rst = 1'b0;
    tick();
    @(negedge clk);
    chk("idle_ram_req", ram_req, 32'h0);

    // Single instruction read, return two cycles after acceptance.
    tick(); drv_i(1, 0, 32'h100); drv_ram(1, 0, 0);
    exp_x(ARB_INSTR, 0, 32'h100); exp_r(ARB_INSTR, 32'hDEAD_BEEF);
    @(negedge clk); chk("s1_dram_ready", dram_ready, 32'h0);
    tick(); idle_all();
    tick(); drv_ram(0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("s1_iram_rvalid", iram_rvalid, 32'h1);
    chk("s1_dram_rvalid", dram_rvalid, 32'h0);
    chk("s1_iram_rdata", iram_rdata, 32'hDEAD_BEEF);
    tick(); idle_all();

    // Collision: data first, instruction on the following cycle.
    tick(); drv_i(1, 1, 32'h200); drv_d(1, 1, 32'h300); drv_ram(1, 0, 0);
    exp_x(ARB_DATA, 1, 32'h300);
    @(negedge clk); chk("s2_iram_ready_lost", iram_ready, 32'h0);
    tick(); drv_d(0, 0, 0);
    exp_x(ARB_INSTR, 1, 32'h200);
    tick(); idle_all();

    // Sustained collisions: alternate under round-robin, always data under fixed priority.
    for (int k = 0; k < 4; k++) begin
      tick();
      drv_i(1, 1, 32'h210 + 32'(4 * k)); drv_d(1, 1, 32'h310 + 32'(4 * k)); drv_ram(1, 0, 0);
`ifdef BUS_ARB_RR_EN
      if (k % 2 == 0) exp_x(ARB_DATA, 1, 32'h310 + 32'(4 * k));
      else            exp_x(ARB_INSTR, 1, 32'h210 + 32'(4 * k));
`else
      exp_x(ARB_DATA, 1, 32'h310 + 32'(4 * k));
`endif
    end
    tick(); idle_all();

    // Stalled data write holds the grant while instruction also requests.
    tick(); drv_d(1, 1, 32'h400); drv_i(1, 1, 32'h500); drv_ram(0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      chk("s3_hold_addr", ram_addr, 32'h400);
      chk("s3_hold_iram_ready", iram_ready, 32'h0);
    end
    tick(); drv_ram(1, 0, 0);
    exp_x(ARB_DATA, 1, 32'h400);
    @(negedge clk); chk("s3_release_iram_ready", iram_ready, 32'h0);
    tick(); drv_d(0, 0, 0);
    exp_x(ARB_INSTR, 1, 32'h500);
    tick(); idle_all();

    // Fill the outstanding-read FIFO.
    for (int k = 0; k < 4; k++) begin
      tick(); drv_i(1, 0, 32'h600 + 32'(4 * k)); drv_ram(1, 0, 0);
      exp_x(ARB_INSTR, 0, 32'h600 + 32'(4 * k));
      exp_r(ARB_INSTR, 32'h1111_0000 + 32'(k));
    end
    tick(); drv_i(1, 0, 32'h610); drv_ram(1, 0, 0);
    @(negedge clk);
    chk("s4_full_ram_req", ram_req, 32'h0);
    chk("s4_full_iram_ready", iram_ready, 32'h0);
    tick(); drv_d(1, 1, 32'h700);
    exp_x(ARB_DATA, 1, 32'h700);
    @(negedge clk);
    chk("s4_full_read_blocked", iram_ready, 32'h0);
    chk("s4_full_write_ready", dram_ready, 32'h1);
    tick(); drv_d(0, 0, 0); drv_ram(1, 1, 32'h1111_0000);
    exp_x(ARB_INSTR, 0, 32'h610); exp_r(ARB_INSTR, 32'h1111_0004);
    @(negedge clk); chk("s4_pushpop_ready", iram_ready, 32'h1);
    tick(); drv_i(1, 0, 32'h614); drv_ram(1, 0, 0);
    @(negedge clk); chk("s4_still_full", iram_ready, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick(); idle_all(); drv_ram(0, 1, 32'h1111_0000 + 32'(k));
    end
    tick(); idle_all();

    // Interleaved reads return in order to their own requester.
    tick(); drv_i(1, 0, 32'h800); drv_ram(1, 0, 0);
    exp_x(ARB_INSTR, 0, 32'h800); exp_r(ARB_INSTR, 32'hA1A1_0001);
    tick(); drv_i(0, 0, 0); drv_d(1, 0, 32'h804);
    exp_x(ARB_DATA, 0, 32'h804); exp_r(ARB_DATA, 32'hA2A2_0002);
    tick(); drv_d(0, 0, 0); drv_i(1, 0, 32'h808);
    exp_x(ARB_INSTR, 0, 32'h808); exp_r(ARB_INSTR, 32'hA3A3_0003);
    tick(); idle_all(); drv_ram(0, 1, 32'hA1A1_0001);
    @(negedge clk); chk("s5_first_to_instr", iram_rvalid, 32'h1);
    tick(); drv_ram(0, 1, 32'hA2A2_0002);
    @(negedge clk); chk("s5_second_to_data", dram_rvalid, 32'h1);
    tick(); drv_ram(0, 1, 32'hA3A3_0003);
    tick(); idle_all();

    // Reset with two reads outstanding; late returns must be dropped.
    tick(); drv_i(1, 0, 32'h900); drv_ram(1, 0, 0);
    exp_x(ARB_INSTR, 0, 32'h900);
    tick(); drv_i(0, 0, 0); drv_d(1, 0, 32'h904);
    exp_x(ARB_DATA, 0, 32'h904);
    tick(); idle_all(); rst = 1'b1;
    @(negedge clk);
    chk("rst2_outputs", {ram_req, iram_ready, dram_ready, iram_rvalid, dram_rvalid}, 32'h0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick(); drv_ram(0, 1, 32'hBAD0_0000 + 32'(k));
      @(negedge clk);
      chk("late_rvalid", {iram_rvalid, dram_rvalid}, 32'h0);
    end
    tick(); idle_all();

    // FIFO is usable again after reset.
    tick(); drv_d(1, 0, 32'hA00); drv_ram(1, 0, 0);
    exp_x(ARB_DATA, 0, 32'hA00); exp_r(ARB_DATA, 32'hC0DE_0001);
    tick(); idle_all();
    tick(); drv_ram(0, 1, 32'hC0DE_0001);
    tick(); idle_all();
    repeat (3) tick();

    chk("xfer_queue_drained", 32'(xfer_q.size()), 32'h0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
